// File: rtl/rvfi_csr_modport_pkg.sv
// Shared types and CSR pre/post state helpers
// for the RVFI CSR observation tap.
package rvfi_csr_modport_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int CSR_ADDR_W = 12;
  localparam int DEFAULT_SHADOW_DEPTH = 16;

  typedef logic [DEFAULT_XLEN-1:0] xword_t;
  typedef logic [CSR_ADDR_W-1:0] csr_addr_t;

  typedef struct packed {
    logic      valid;
    csr_addr_t tag;
    xword_t    data;
    xword_t    known;
  } shadow_entry_t;

  typedef struct packed {
    logic      valid;
    csr_addr_t addr;
    xword_t    pre;
    xword_t    post;
    logic      read;
    logic      written;
    logic      changed;
    logic      mismatch;
    xword_t    mm_bits;
  } csr_obs_t;

  function automatic xword_t csr_pre_state(
    input xword_t rdata,
    input xword_t rmask
  );
    return rdata & rmask;
  endfunction

  function automatic xword_t csr_post_state(
    input xword_t rdata,
    input xword_t rmask,
    input xword_t wdata,
    input xword_t wmask
  );
    return (rdata & rmask & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/rvfi_csr_modport_shadow_table.sv
// Direct-mapped shadow of last-known CSR values:
// tag lookup plus masked merge on update.
module rvfi_csr_shadow_table
  import rvfi_csr_modport_pkg::*;
#(
  parameter int DEPTH = DEFAULT_SHADOW_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  csr_addr_t addr_i,
  output logic      hit_o,
  output xword_t    data_o,
  output xword_t    known_o,
  input  logic      upd_en_i,
  input  xword_t    upd_acc_i,
  input  xword_t    upd_post_i
);

  localparam int IDX_W = $clog2(DEPTH);

  shadow_entry_t tbl_q [DEPTH];
  shadow_entry_t ent_d;
  shadow_entry_t ent;
  logic [IDX_W-1:0] idx;

  assign idx = addr_i[IDX_W-1:0];
  assign ent = tbl_q[idx];

  always_comb begin
    hit_o   = ent.valid && (ent.tag == addr_i);
    data_o  = ent.data;
    known_o = ent.known;
  end

  // Miss evicts whatever aliasing CSR lived here.
  always_comb begin
    ent_d = ent;
    if (hit_o) begin
      ent_d.data  = (ent.data & ~upd_acc_i)
                  | (upd_post_i & upd_acc_i);
      ent_d.known = ent.known | upd_acc_i;
    end else begin
      ent_d.valid = 1'b1;
      ent_d.tag   = addr_i;
      ent_d.data  = upd_post_i & upd_acc_i;
      ent_d.known = upd_acc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (upd_en_i) begin
      tbl_q[idx] <= ent_d;
    end
  end

endmodule

// File: rtl/rvfi_csr_modport.sv
// Passive RVFI CSR tap: pre/post state math,
// shadow consistency check, registered outputs.
module rvfi_csr_modport
  import rvfi_csr_modport_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int SHADOW_DEPTH = DEFAULT_SHADOW_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rvfi_valid,
  input  logic [ADDR_W-1:0] rvfi_csr_addr,
  input  logic [XLEN-1:0]   rvfi_csr_rmask,
  input  logic [XLEN-1:0]   rvfi_csr_wmask,
  input  logic [XLEN-1:0]   rvfi_csr_rdata,
  input  logic [XLEN-1:0]   rvfi_csr_wdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [XLEN-1:0]   pre_state,
  output logic [XLEN-1:0]   post_state,
  output logic              csr_read,
  output logic              csr_written,
  output logic              csr_changed,
  output logic              mismatch,
  output logic [XLEN-1:0]   mismatch_bits
);

  csr_obs_t obs_d, obs_q;
  logic     sh_hit;
  xword_t   sh_data, sh_known;
  xword_t   pre, post, diff, acc;
  logic     upd_en;

  rvfi_csr_shadow_table #(
    .DEPTH(SHADOW_DEPTH)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .addr_i    (rvfi_csr_addr),
    .hit_o     (sh_hit),
    .data_o    (sh_data),
    .known_o   (sh_known),
    .upd_en_i  (upd_en),
    .upd_acc_i (acc),
    .upd_post_i(post)
  );

  // Compare uses the pre-update shadow; write lands at the edge.
  always_comb begin
    pre  = csr_pre_state(rvfi_csr_rdata, rvfi_csr_rmask);
    post = csr_post_state(rvfi_csr_rdata, rvfi_csr_rmask,
                          rvfi_csr_wdata, rvfi_csr_wmask);
    diff = (rvfi_csr_rdata ^ sh_data)
         & rvfi_csr_rmask & sh_known;
    acc  = rvfi_csr_rmask | rvfi_csr_wmask;
    upd_en = rvfi_valid && (|acc);
    obs_d = '0;
    if (rvfi_valid) begin
      obs_d.valid    = 1'b1;
      obs_d.addr     = rvfi_csr_addr;
      obs_d.pre      = pre;
      obs_d.post     = post;
      obs_d.read     = |rvfi_csr_rmask;
      obs_d.written  = |rvfi_csr_wmask;
      obs_d.changed  = post != pre;
      obs_d.mismatch = sh_hit && (|diff);
      obs_d.mm_bits  = sh_hit ? diff : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      obs_q <= '0;
    end else begin
      obs_q <= obs_d;
    end
  end

  assign out_valid     = obs_q.valid;
  assign out_addr      = obs_q.addr;
  assign pre_state     = obs_q.pre;
  assign post_state    = obs_q.post;
  assign csr_read      = obs_q.read;
  assign csr_written   = obs_q.written;
  assign csr_changed   = obs_q.changed;
  assign mismatch      = obs_q.mismatch;
  assign mismatch_bits = obs_q.mm_bits;

endmodule

// File: tb/tb_rvfi_csr_modport.sv
// Directed bench for the RVFI CSR tap:
// hand-computed vectors, one checker task.
module tb_rvfi_csr_modport;

  logic        clk = 1'b0;
  logic        reset;
  logic        rvfi_valid;
  logic [11:0] rvfi_csr_addr;
  logic [31:0] rvfi_csr_rmask;
  logic [31:0] rvfi_csr_wmask;
  logic [31:0] rvfi_csr_rdata;
  logic [31:0] rvfi_csr_wdata;
  logic        out_valid;
  logic [11:0] out_addr;
  logic [31:0] pre_state;
  logic [31:0] post_state;
  logic        csr_read;
  logic        csr_written;
  logic        csr_changed;
  logic        mismatch;
  logic [31:0] mismatch_bits;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rvfi_csr_modport dut (
    .clk           (clk),
    .reset         (reset),
    .rvfi_valid    (rvfi_valid),
    .rvfi_csr_addr (rvfi_csr_addr),
    .rvfi_csr_rmask(rvfi_csr_rmask),
    .rvfi_csr_wmask(rvfi_csr_wmask),
    .rvfi_csr_rdata(rvfi_csr_rdata),
    .rvfi_csr_wdata(rvfi_csr_wdata),
    .out_valid     (out_valid),
    .out_addr      (out_addr),
    .pre_state     (pre_state),
    .post_state    (post_state),
    .csr_read      (csr_read),
    .csr_written   (csr_written),
    .csr_changed   (csr_changed),
    .mismatch      (mismatch),
    .mismatch_bits (mismatch_bits)
  );

  task automatic check_eq(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic        rst,
    input logic        v,
    input logic [11:0] a,
    input logic [31:0] rm,
    input logic [31:0] rd,
    input logic [31:0] wm,
    input logic [31:0] wd
  );
    @(negedge clk);
    reset          = rst;
    rvfi_valid     = v;
    rvfi_csr_addr  = a;
    rvfi_csr_rmask = rm;
    rvfi_csr_rdata = rd;
    rvfi_csr_wmask = wm;
    rvfi_csr_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(
    input string       t,
    input logic        ov,
    input logic [11:0] a,
    input logic [31:0] pre,
    input logic [31:0] post,
    input logic        rd,
    input logic        wr,
    input logic        ch,
    input logic        mm,
    input logic [31:0] bits
  );
    check_eq({t, ".valid"}, 64'(out_valid), 64'(ov));
    check_eq({t, ".addr"}, 64'(out_addr), 64'(a));
    check_eq({t, ".pre"}, 64'(pre_state), 64'(pre));
    check_eq({t, ".post"}, 64'(post_state), 64'(post));
    check_eq({t, ".read"}, 64'(csr_read), 64'(rd));
    check_eq({t, ".written"}, 64'(csr_written), 64'(wr));
    check_eq({t, ".changed"}, 64'(csr_changed), 64'(ch));
    check_eq({t, ".mm"}, 64'(mismatch), 64'(mm));
    check_eq({t, ".mmbits"}, 64'(mismatch_bits), 64'(bits));
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    reset = 1'b1;
    rvfi_valid = 1'b0;
    rvfi_csr_addr = '0;
    rvfi_csr_rmask = '0;
    rvfi_csr_rdata = '0;
    rvfi_csr_wmask = '0;
    rvfi_csr_wdata = '0;

    step(1, 0, 12'h000, 0, 0, 0, 0);
    step(1, 0, 12'h000, 0, 0, 0, 0);
    check_out("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 12'h000, 0, 0, 0, 0);
    check_out("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 12'h300, ALL, 32'h1800, 32'h8, 32'h8);
    check_out("rw300", 1, 12'h300, 32'h1800, 32'h1808,
              1, 1, 1, 0, 0);

    step(0, 1, 12'h300, ALL, 32'h1808, 0, 0);
    check_out("rd_ok", 1, 12'h300, 32'h1808, 32'h1808,
              1, 0, 0, 0, 0);

    step(0, 1, 12'h300, ALL, 32'h1800, 0, 0);
    check_out("rd_bad", 1, 12'h300, 32'h1800, 32'h1800,
              1, 0, 0, 1, 32'h8);

    step(0, 1, 12'h310, 0, 0, 32'hFFFF, 32'hFFFF);
    check_out("alias", 1, 12'h310, 0, 32'hFFFF,
              0, 1, 1, 0, 0);

    step(0, 1, 12'h300, ALL, 32'h1234_5678, 0, 0);
    check_out("evict", 1, 12'h300, 32'h1234_5678,
              32'h1234_5678, 1, 0, 0, 0, 0);

    step(0, 0, 12'h300, ALL, 0, 32'hF, 32'hF);
    check_out("novalid", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 12'h300, ALL, 32'h1234_5670, 0, 0);
    check_out("untouched", 1, 12'h300, 32'h1234_5670,
              32'h1234_5670, 1, 0, 0, 1, 32'h8);

    step(0, 1, 12'h300, 0, 0, 32'hFF, 32'hAA);
    check_out("wr_low", 1, 12'h300, 0, 32'hAA,
              0, 1, 1, 0, 0);
    step(0, 1, 12'h300, ALL, 32'h1234_56AA, 0, 0);
    check_out("b2b", 1, 12'h300, 32'h1234_56AA,
              32'h1234_56AA, 1, 0, 0, 0, 0);

    step(0, 1, 12'h305, 0, 0, 32'hFF00, 32'h1200);
    check_out("wr305", 1, 12'h305, 0, 32'h1200,
              0, 1, 1, 0, 0);
    step(0, 1, 12'h305, ALL, 32'hFFFF_12FF, 0, 0);
    check_out("known", 1, 12'h305, 32'hFFFF_12FF,
              32'hFFFF_12FF, 1, 0, 0, 0, 0);
    step(0, 1, 12'h305, ALL, 32'h0000_1300, 0, 0);
    check_out("full", 1, 12'h305, 32'h1300, 32'h1300,
              1, 0, 0, 1, 32'hFFFF_01FF);

    step(0, 1, 12'h305, 0, 32'hDEAD_BEEF, 0, 32'h5);
    check_out("nomask", 1, 12'h305, 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 12'h305, 32'h0000_00F0, 32'hFFFF_1320, 0, 0);
    check_out("partial", 1, 12'h305, 32'h20, 32'h20,
              1, 0, 0, 1, 32'h20);

    step(1, 1, 12'h307, 0, 0, ALL, 32'h55);
    check_out("rst_wr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 12'h307, ALL, 32'h1, 0, 0);
    check_out("rst_miss", 1, 12'h307, 32'h1, 32'h1,
              1, 0, 0, 0, 0);
    step(0, 1, 12'h300, ALL, 32'h0, 0, 0);
    check_out("rst_clr", 1, 12'h300, 0, 0, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
